mem_responder: RTL and testbench

//  Memory-side responder for the multi-cycle core's unified instruction/data port.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_array.sv | 29 ++
 rtl/mem_responder.sv | 144 ++++++++++++++
 tb/tb_mem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-side responder and its word array.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } mem_state_t;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   // Replace only the byte lanes whose enable bit is set.
   function automatic logic [WORD_W-1:0] be_merge(input logic [WORD_W-1:0] old_w,
                                                  input logic [WORD_W-1:0] new_w,
                                                  input logic [BE_W-1:0]   be);
      logic [WORD_W-1:0] res;
      res = old_w;
      for (int i = 0; i < BE_W; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word array: synchronous byte-enable write, registered read.
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = 8
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH_WORDS];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) r_mem[idx] <= be_merge(r_mem[idx], wdata, be);
         else    r_rdata    <= r_mem[idx];
      end
   end

   assign rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: one outstanding request, LATENCY wait cycles, then a
// read-data or write-ack response held until the core takes it.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2,
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   input  logic [BE_W-1:0]   req_be,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        state
);

   localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]        LAT_L   = 4'(LATENCY);
   localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH_WORDS);

   mem_state_t        r_state;
   logic [3:0]        r_cnt;
   logic              r_err;
   logic              r_rsp_valid;
   logic [WORD_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;

   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [WORD_W-1:0] r_wdata;
   logic [BE_W-1:0]   r_be;

   logic              w_idle;
   logic              w_acc;
   logic              w_acc_we;
   logic [ADDR_W-1:0] w_acc_addr;
   logic [WORD_W-1:0] w_acc_wdata;
   logic [BE_W-1:0]   w_acc_be;
   logic              w_err;
   logic [WORD_W-1:0] w_rdata;

   assign w_idle = (r_state == IDLE);

   // With zero latency the access is issued straight from the request inputs.
   assign w_acc_we    = w_idle ? req_we    : r_we;
   assign w_acc_addr  = w_idle ? req_addr  : r_addr;
   assign w_acc_wdata = w_idle ? req_wdata : r_wdata;
   assign w_acc_be    = w_idle ? req_be    : r_be;

   assign w_acc = reset &&
                  ((w_idle && req_valid && (LAT_L == 4'd0)) ||
                   ((r_state == WAIT) && (r_cnt <= 4'd1)));

   assign w_err = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[ADDR_W-1:2] >= DEPTH_L);

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (w_acc && !w_err),
      .we    (w_acc_we),
      .be    (w_acc_be),
      .idx   (w_acc_addr[IDX_W+1:2]),
      .wdata (w_acc_wdata),
      .rdata (w_rdata)
   );

   always_ff @(posedge clk) begin
      if (w_idle && req_valid) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_be    <= req_be;
      end
   end

   // The first RESP cycle waits for the registered array read; rsp_valid rises after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_err       <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_cnt <= LAT_L;
                  if (LAT_L == 4'd0) begin
                     r_state <= RESP;
                     r_err   <= w_err;
                  end else begin
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt <= 4'd1) begin
                  r_state <= RESP;
                  r_err   <= w_err;
               end
            end
            RESP: begin
               if (!r_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= r_err;
                  r_rsp_rdata <= (r_we || r_err) ? '0 : w_rdata;
               end else if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_cnt       <= '0;
               r_rsp_valid <= 1'b0;
               r_rsp_rdata <= '0;
               r_rsp_err   <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready = w_idle && reset;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign state     = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder, run side by side at LATENCY=2 and LATENCY=0.
module tb_mem_responder;
   import mem_pkg::*;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]       reset, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
   logic [1:0][31:0] req_addr, req_wdata, rsp_rdata;
   logic [1:0][3:0]  req_be;
   logic [1:0][1:0]  state;

   exp_t        exp_q [$];
   logic [31:0] model [2][256];
   int          n_checks = 0;
   int          n_fail   = 0;

   mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .ADDR_W(32)) u_dut_l2 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .state(state[0])
   );

   mem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .ADDR_W(32)) u_dut_l0 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .state(state[1])
   );

   function automatic int lat_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic predict(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
      exp_t e;
      logic err;
      err = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd256);
      e.err   = err;
      e.rdata = 32'h0;
      if (!err) begin
         if (we) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) model[d][addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
         end else begin
            e.rdata = model[d][addr[9:2]];
         end
      end
      exp_q.push_back(e);
   endtask

   // Called on a negedge; returns on the negedge after the accepting edge.
   task automatic send_req(input int d, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, output int acc_cyc);
      int waited = 0;
      while (req_ready[d] !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check_eq($sformatf("d%0d req_ready before accept", d), 32'(req_ready[d]), 32'd1);
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      req_valid[d] = 1'b1;
      @(negedge clk);
      acc_cyc      = cyc;
      req_valid[d] = 1'b0;
      req_we[d]    = ~we;
      req_addr[d]  = $urandom;
      req_wdata[d] = $urandom;
      req_be[d]    = 4'($urandom);
   endtask

   task automatic get_rsp(input int d, input int hold, input int acc_cyc);
      exp_t e;
      int   waited = 0;
      while (rsp_valid[d] !== 1'b1 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check_eq($sformatf("d%0d rsp_valid arrives", d), 32'(rsp_valid[d]), 32'd1);
      check_eq($sformatf("d%0d latency", d), 32'(cyc - acc_cyc), 32'(lat_of(d) + 1));
      if (exp_q.size() == 0) begin
         check_eq($sformatf("d%0d scoreboard empty", d), 32'd0, 32'd1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      check_eq($sformatf("d%0d rdata", d), rsp_rdata[d], e.rdata);
      check_eq($sformatf("d%0d err", d), 32'(rsp_err[d]), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
         req_valid[d] = 1'b1;
         req_we[d]    = 1'b1;
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'hFFFF_FFFF;
         req_be[d]    = 4'hF;
         @(negedge clk);
         check_eq($sformatf("d%0d bp rsp_valid", d), 32'(rsp_valid[d]), 32'd1);
         check_eq($sformatf("d%0d bp rdata", d), rsp_rdata[d], e.rdata);
         check_eq($sformatf("d%0d bp req_ready", d), 32'(req_ready[d]), 32'd0);
         check_eq($sformatf("d%0d bp state", d), 32'(state[d]), 32'd2);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b1;
      @(negedge clk);
      rsp_ready[d] = 1'b0;
      check_eq($sformatf("d%0d rsp_valid cleared", d), 32'(rsp_valid[d]), 32'd0);
      check_eq($sformatf("d%0d rdata cleared", d), rsp_rdata[d], 32'd0);
      check_eq($sformatf("d%0d err cleared", d), 32'(rsp_err[d]), 32'd0);
      check_eq($sformatf("d%0d back to idle", d), 32'(state[d]), 32'd0);
   endtask

   task automatic do_req(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input int hold);
      int acc;
      predict(d, we, addr, wdata, be);
      send_req(d, we, addr, wdata, be, acc);
      get_rsp(d, hold, acc);
   endtask

   // Reset one cycle after accepting a write; only a zero-latency write has already landed.
   task automatic abort_write(input int d, input logic [31:0] addr, input logic [31:0] wdata);
      int acc;
      send_req(d, 1'b1, addr, wdata, 4'hF, acc);
      reset[d] = 1'b0;
      #1;
      check_eq($sformatf("d%0d abort state", d), 32'(state[d]), 32'd0);
      check_eq($sformatf("d%0d abort rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
      if (lat_of(d) == 0) model[d][addr[9:2]] = wdata;
      @(negedge clk);
      reset[d] = 1'b1;
      @(negedge clk);
      check_eq($sformatf("d%0d ready after abort", d), 32'(req_ready[d]), 32'd1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         reset[d]     = 1'b0;
         req_valid[d] = 1'b1;
         req_we[d]    = 1'b0;
         req_addr[d]  = 32'h10;
         req_wdata[d] = 32'h0;
         req_be[d]    = 4'hF;
         rsp_ready[d] = 1'b0;
         for (int w = 0; w < 256; w++) model[d][w] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d reset state", d), 32'(state[d]), 32'd0);
         check_eq($sformatf("d%0d reset rsp_valid", d), 32'(rsp_valid[d]), 32'd0);
         check_eq($sformatf("d%0d reset rdata", d), rsp_rdata[d], 32'd0);
         check_eq($sformatf("d%0d reset err", d), 32'(rsp_err[d]), 32'd0);
      end
      req_valid = 2'b00;
      reset     = 2'b11;
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         check_eq($sformatf("d%0d ready after reset", d), 32'(req_ready[d]), 32'd1);

      for (int d = 0; d < 2; d++) begin
         do_req(d, 1'b1, 32'h10,  32'hDEAD_BEEF, 4'hF, 0);
         do_req(d, 1'b0, 32'h10,  32'h0,         4'h0, 0);
         do_req(d, 1'b1, 32'h10,  32'h0000_0011, 4'h1, 0);
         do_req(d, 1'b0, 32'h10,  32'h0,         4'h0, 0);
         do_req(d, 1'b1, 32'h10,  32'hFFFF_FFFF, 4'h0, 0);
         do_req(d, 1'b0, 32'h10,  32'h0,         4'h0, 0);
         do_req(d, 1'b0, 32'h13,  32'h0,         4'h0, 0);
         do_req(d, 1'b1, 32'h0,   32'h1234_5678, 4'hF, 0);
         do_req(d, 1'b1, 32'h400, 32'hBAD0_BAD0, 4'hF, 0);
         do_req(d, 1'b0, 32'h0,   32'h0,         4'h0, 0);
         do_req(d, 1'b0, 32'h400, 32'h0,         4'h0, 0);
         do_req(d, 1'b1, 32'h3FC, 32'hA5A5_5A5A, 4'hF, 0);
         do_req(d, 1'b0, 32'h3FC, 32'h0,         4'h0, 0);
         do_req(d, 1'b0, 32'h10,  32'h0,         4'h0, 5);
         do_req(d, 1'b0, 32'h0,   32'h0,         4'h0, 0);
         do_req(d, 1'b1, 32'h20,  32'hCAFE_F00D, 4'hF, 0);
         abort_write(d, 32'h20, 32'h0BAD_F00D);
         do_req(d, 1'b0, 32'h20,  32'h0,         4'h0, 0);
      end

      check_eq("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
